// File: rtl/exotiny_qspi_pkg.sv
// exotiny_qspi_pkg
// Shared types and constants for the exotiny QSPI memory controller:
// transaction state encoding, SPI phase lengths, data-line output-enable
// patterns and small helpers for byte-lane handling.
package exotiny_qspi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DUMMY,
      DATA,
      DONE
   } state_t;

   // SCK periods per phase
   localparam int CMD_CLKS  = 8;
   localparam int ADDR_CLKS = 6;
   localparam int MODE_CLKS = 2;

   // Data-line output enables, 1 = drive. During the single-bit command
   // phase WP#/HOLD# (sd[3:2]) are driven high and sd[1] is the input.
   localparam logic [3:0] OEN_SINGLE = 4'b1101;
   localparam logic [3:0] OEN_QUAD   = 4'hF;
   localparam logic [3:0] OEN_IN     = 4'h0;

   // Index of the lowest set byte enable (0 if none set).
   function automatic logic [1:0] lowest_lane(input logic [3:0] sel);
      lowest_lane = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (sel[i]) begin
            lowest_lane = 2'(i);
         end
      end
   endfunction

   // Number of set byte enables.
   function automatic logic [2:0] lane_count(input logic [3:0] sel);
      lane_count = {2'b00, sel[0]} + {2'b00, sel[1]} + {2'b00, sel[2]} + {2'b00, sel[3]};
   endfunction

   // Reverse byte order: the bus streams the lowest-addressed byte first,
   // so it has to sit in the top byte of the MSB-first shift register.
   function automatic logic [31:0] byte_swap(input logic [31:0] w);
      byte_swap = {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/exotiny_qspi_mem.sv
// exotiny_qspi_mem
// Turns single-word bus requests into QSPI transactions on a bus shared by
// a flash ROM (addr[24]=0) and a PSRAM (addr[24]=1). SCK runs at clk/2.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   stb_i/we_i/addr_i    request strobe (held until ack_o), write flag, byte address
//   sel_i/wdata_i        write byte enables (contiguous) and little-endian data
//   rdata_o/ack_o        read data and one-cycle completion pulse
//   mem_cs_rom_on/_ram_on active-low chip selects
//   mem_sck_o            SPI clock, idles low
//   mem_sd_o/_oen_o/_i   shared quad data lines: out, per-line drive enable, in
module exotiny_qspi_mem
   import exotiny_qspi_pkg::*;
#(
   parameter logic [7:0] ROM_CMD_RD = 8'hEB,
   parameter logic [7:0] RAM_CMD_RD = 8'hEB,
   parameter logic [7:0] RAM_CMD_WR = 8'h38,
   parameter int         DUMMY_CLKS = 6
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [24:0] addr_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        ack_o,
   output logic        mem_cs_rom_on,
   output logic        mem_cs_ram_on,
   output logic        mem_sck_o,
   output logic [3:0]  mem_sd_o,
   output logic [3:0]  mem_sd_oen_o,
   input  logic [3:0]  mem_sd_i
);

   localparam logic [4:0] CMD_LAST   = 5'(CMD_CLKS - 1);
   localparam logic [4:0] ADDR_LAST  = 5'(ADDR_CLKS - 1);
   localparam logic [4:0] MODE_END   = 5'(MODE_CLKS);
   localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_CLKS - 1);

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;        // SCK period index within the current phase
   logic        sck_q, sck_d;
   logic [31:0] sr_q, sr_d;          // cmd/addr/data shift register, MSB out first
   logic [31:0] wdata_q, wdata_d;    // write bytes, first byte in [31:24]
   logic [2:0]  nbytes_q, nbytes_d;
   logic        we_q, we_d;
   logic        ram_q, ram_d;
   logic        cs_rom_q, cs_rom_d;
   logic        cs_ram_q, cs_ram_d;
   logic [3:0]  sd_o_q, sd_o_d;
   logic [3:0]  oen_q, oen_d;
   logic        ack_q, ack_d;
   logic [31:0] rdata_q, rdata_d;

   logic [1:0]  lane;
   logic [4:0]  data_last;

   // Byte offset comes from sel_i, not from the low address bits.
   logic unused_addr;
   assign unused_addr = ^addr_i[1:0];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sck_d     = sck_q;
      sr_d      = sr_q;
      wdata_d   = wdata_q;
      nbytes_d  = nbytes_q;
      we_d      = we_q;
      ram_d     = ram_q;
      rdata_d   = rdata_q;
      lane      = lowest_lane(sel_i);
      data_last = we_q ? (5'({nbytes_q, 1'b0}) - 5'd1) : 5'd7;

      case (state_q)
         IDLE: begin
            if (stb_i) begin
               we_d  = we_i;
               ram_d = addr_i[24];
               if (we_i && !addr_i[24]) begin
                  // ROM is read-only: complete without touching the bus.
                  state_d = DONE;
               end else begin
                  state_d  = CMD;
                  cnt_d    = '0;
                  sck_d    = 1'b0;
                  wdata_d  = byte_swap(wdata_i >> {lane, 3'b000});
                  nbytes_d = (lane_count(sel_i) == 3'd0) ? 3'd1 : lane_count(sel_i);
                  if (we_i) begin
                     sr_d = {RAM_CMD_WR, addr_i[23:2], lane};
                  end else begin
                     sr_d = {(addr_i[24] ? RAM_CMD_RD : ROM_CMD_RD), addr_i[23:2], 2'b00};
                  end
               end
            end
         end
         CMD, ADDR, DUMMY, DATA: begin
            sck_d = ~sck_q;
            // Everything advances on the falling SCK edge; the rising edge
            // only samples mem_sd_i (taken at the end of the high cycle).
            if (sck_q) begin
               cnt_d = cnt_q + 5'd1;
               case (state_q)
                  CMD: begin
                     sr_d = {sr_q[30:0], 1'b0};
                     if (cnt_q == CMD_LAST) begin
                        state_d = ADDR;
                        cnt_d   = '0;
                     end
                  end
                  ADDR: begin
                     sr_d = {sr_q[27:0], 4'h0};
                     if (cnt_q == ADDR_LAST) begin
                        cnt_d = '0;
                        if (we_q) begin
                           state_d = DATA;
                           sr_d    = wdata_q;
                        end else begin
                           state_d = DUMMY;
                        end
                     end
                  end
                  DUMMY: begin
                     if (cnt_q == DUMMY_LAST) begin
                        state_d = DATA;
                        cnt_d   = '0;
                     end
                  end
                  default: begin
                     sr_d = {sr_q[27:0], (we_q ? 4'h0 : mem_sd_i)};
                     if (cnt_q == data_last) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        if (!we_q) begin
                           rdata_d = byte_swap(sr_d);
                        end
                     end
                  end
               endcase
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registered pin values, derived from the next state so that every
   // output changes together with the state it belongs to.
   always_comb begin
      cs_rom_d = 1'b1;
      cs_ram_d = 1'b1;
      sd_o_d   = 4'h0;
      oen_d    = OEN_IN;
      ack_d    = 1'b0;
      case (state_d)
         CMD: begin
            oen_d  = OEN_SINGLE;
            sd_o_d = {3'b110, sr_d[31]};
         end
         ADDR: begin
            oen_d  = OEN_QUAD;
            sd_o_d = sr_d[31:28];
         end
         DUMMY: begin
            // Mode byte 8'h00 first, then release the lines for turnaround.
            if (cnt_d < MODE_END) begin
               oen_d = OEN_QUAD;
            end
         end
         DATA: begin
            if (we_d) begin
               oen_d  = OEN_QUAD;
               sd_o_d = sr_d[31:28];
            end
         end
         DONE: begin
            ack_d = 1'b1;
         end
         default: begin
         end
      endcase
      if (state_d inside {CMD, ADDR, DUMMY, DATA}) begin
         cs_rom_d = ram_d;
         cs_ram_d = ~ram_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sck_q    <= 1'b0;
         sr_q     <= '0;
         wdata_q  <= '0;
         nbytes_q <= 3'd1;
         we_q     <= 1'b0;
         ram_q    <= 1'b0;
         cs_rom_q <= 1'b1;
         cs_ram_q <= 1'b1;
         sd_o_q   <= 4'h0;
         oen_q    <= OEN_IN;
         ack_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sck_q    <= sck_d;
         sr_q     <= sr_d;
         wdata_q  <= wdata_d;
         nbytes_q <= nbytes_d;
         we_q     <= we_d;
         ram_q    <= ram_d;
         cs_rom_q <= cs_rom_d;
         cs_ram_q <= cs_ram_d;
         sd_o_q   <= sd_o_d;
         oen_q    <= oen_d;
         ack_q    <= ack_d;
         rdata_q  <= rdata_d;
      end
   end

   assign rdata_o       = rdata_q;
   assign ack_o         = ack_q;
   assign mem_cs_rom_on = cs_rom_q;
   assign mem_cs_ram_on = cs_ram_q;
   assign mem_sck_o     = sck_q;
   assign mem_sd_o      = sd_o_q;
   assign mem_sd_oen_o  = oen_q;

endmodule

// File: tb/tb_exotiny_qspi_mem.sv
// tb_exotiny_qspi_mem
// Drives bus requests into exotiny_qspi_mem, plays the ROM/PSRAM devices on
// the QSPI side, and checks every completion against a scoreboard built from
// a byte-level memory model at request time.
module tb_exotiny_qspi_mem;

   localparam logic [7:0] ROM_CMD_RD = 8'hEB;
   localparam logic [7:0] RAM_CMD_RD = 8'hEB;
   localparam logic [7:0] RAM_CMD_WR = 8'h38;
   localparam int         DUMMY_CLKS = 6;
   localparam int         MODE_CLKS  = 2;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        stb_i = 1'b0;
   logic        we_i = 1'b0;
   logic [24:0] addr_i = '0;
   logic [3:0]  sel_i = '0;
   logic [31:0] wdata_i = '0;
   logic [31:0] rdata_o;
   logic        ack_o;
   logic        mem_cs_rom_on;
   logic        mem_cs_ram_on;
   logic        mem_sck_o;
   logic [3:0]  mem_sd_o;
   logic [3:0]  mem_sd_oen_o;
   logic [3:0]  mem_sd_i = 4'h0;

   exotiny_qspi_mem #(
      .ROM_CMD_RD(ROM_CMD_RD),
      .RAM_CMD_RD(RAM_CMD_RD),
      .RAM_CMD_WR(RAM_CMD_WR),
      .DUMMY_CLKS(DUMMY_CLKS)
   ) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .stb_i(stb_i),
      .we_i(we_i),
      .addr_i(addr_i),
      .sel_i(sel_i),
      .wdata_i(wdata_i),
      .rdata_o(rdata_o),
      .ack_o(ack_o),
      .mem_cs_rom_on(mem_cs_rom_on),
      .mem_cs_ram_on(mem_cs_ram_on),
      .mem_sck_o(mem_sck_o),
      .mem_sd_o(mem_sd_o),
      .mem_sd_oen_o(mem_sd_oen_o),
      .mem_sd_i(mem_sd_i)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int          accept;
      int          lat;
      bit          bus;
      bit          rd;
      logic [31:0] rdata;
      logic [7:0]  cmd;
      logic [23:0] addr;
      bit          ram;
      int          nnib;
      logic [63:0] wnib;
   } exp_t;

   typedef struct {
      logic [7:0]  cmd;
      logic [23:0] addr;
      bit          ram;
      int          nnib;
      logic [63:0] wnib;
      int          bad;
   } obs_t;

   exp_t exp_q[$];
   obs_t obs_q[$];

   logic [7:0]  ref_ram [int];   // what the bench believes RAM holds
   logic [7:0]  dev_ram [int];   // what the PSRAM model actually received
   logic [31:0] last_rdata = '0;
   logic [3:0]  sel_tab [0:9];

   function automatic logic [7:0] rom_byte(input int a);
      if (a >= 'h100 && a <= 'h103) return 8'((a - 'h100 + 1) * 'h11);
      return 8'(a ^ (a >> 8) ^ 'h5A);
   endfunction

   function automatic logic [7:0] ram_init(input int a);
      return 8'(a * 7 + 'h3C);
   endfunction

   function automatic logic [7:0] ref_rd(input bit ram, input int a);
      if (!ram) return rom_byte(a);
      if (ref_ram.exists(a)) return ref_ram[a];
      return ram_init(a);
   endfunction

   function automatic logic [7:0] dev_rd(input bit ram, input int a);
      if (!ram) return rom_byte(a);
      if (dev_ram.exists(a)) return dev_ram[a];
      return ram_init(a);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Issue one request (called just after a rising edge) and queue its
   // expected outcome.
   task automatic issue(input bit we, input logic [24:0] a, input logic [3:0] sel,
                        input logic [31:0] wd);
      exp_t e;
      int   lo;
      int   n;
      int   base;
      stb_i   = 1'b1;
      we_i    = we;
      addr_i  = a;
      sel_i   = sel;
      wdata_i = wd;
      e = '{default: 0};
      e.accept = cyc;
      e.ram    = a[24];
      e.rdata  = last_rdata;
      if (we && !a[24]) begin
         e.lat = 1;
         e.bus = 1'b0;
      end else if (we) begin
         lo = 0;
         while (lo < 3 && !sel[lo]) lo++;
         n = 0;
         for (int i = 0; i < 4; i++) n += int'(sel[i]);
         base   = int'({a[23:2], 2'b00}) + lo;
         e.bus  = 1'b1;
         e.cmd  = RAM_CMD_WR;
         e.addr = 24'(base);
         e.nnib = 2 * n;
         for (int i = 0; i < n; i++) begin
            e.wnib = {e.wnib[55:0], wd[8*(lo+i) +: 8]};
            ref_ram[base + i] = wd[8*(lo+i) +: 8];
         end
         e.lat = 2 * (8 + 6 + 2 * n) + 1;
      end else begin
         base   = int'({a[23:2], 2'b00});
         e.bus  = 1'b1;
         e.rd   = 1'b1;
         e.cmd  = a[24] ? RAM_CMD_RD : ROM_CMD_RD;
         e.addr = 24'(base);
         e.nnib = 8;
         for (int i = 0; i < 4; i++) e.rdata[8*i +: 8] = ref_rd(a[24], base + i);
         last_rdata = e.rdata;
         e.lat = 2 * (8 + 6 + DUMMY_CLKS + 8) + 1;
      end
      $display("[TB] cycle %0d: %s addr=%07h sel=%b wdata=%08h expect ack +%0d",
               cyc, (we ? "write" : "read "), a, sel, wd, e.lat);
      exp_q.push_back(e);
   endtask

   // Wait (bounded) for ack_o, then return just after the next rising edge
   // with stb_i still asserted.
   task automatic wait_ack();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack_o && n < 300);
      if (!ack_o) begin
         tests++;
         fails++;
         $display("FAIL ack_timeout: no ack_o after %0d cycles, expected one", n);
         if (exp_q.size() > 0) void'(exp_q.pop_back());
      end
      @(posedge clk);
      #1;
   endtask

   // stb_i must stay up until ack_o.
   assert property (@(posedge clk) disable iff (rst_i) (stb_i && !ack_o) |=> (stb_i || rst_i))
      else $error("stb_i dropped before ack_o");

   // QSPI device model and completion monitor.
   obs_t w;
   bit   in_win = 1'b0;
   int   k = 0;
   initial begin
      exp_t        e;
      obs_t        o;
      bit          cs_low;
      int          j;
      logic [7:0]  b;
      w = '{default: 0};
      forever begin
         @(negedge clk);
         if (rst_i) begin
            in_win = 1'b0;
         end else begin
            cs_low = !mem_cs_rom_on || !mem_cs_ram_on;
            if (cs_low) check("cs_exclusive", 64'(!mem_cs_rom_on && !mem_cs_ram_on), 64'd0);
            if (cs_low && !in_win) begin
               in_win = 1'b1;
               k      = 0;
               w      = '{default: 0};
               w.ram  = !mem_cs_ram_on;
            end
            if (in_win && cs_low && mem_sck_o) begin
               if (k < 8) begin
                  if (mem_sd_oen_o != 4'b1101 || mem_sd_o[3:1] != 3'b110) w.bad++;
                  w.cmd = {w.cmd[6:0], mem_sd_o[0]};
               end else if (k < 14) begin
                  if (mem_sd_oen_o != 4'hF) w.bad++;
                  w.addr = {w.addr[19:0], mem_sd_o};
               end else if (w.ram && w.cmd == RAM_CMD_WR) begin
                  if (mem_sd_oen_o != 4'hF) w.bad++;
                  w.wnib = {w.wnib[59:0], mem_sd_o};
                  w.nnib++;
               end else if (k < 14 + MODE_CLKS) begin
                  if (mem_sd_oen_o != 4'hF || mem_sd_o != 4'h0) w.bad++;
               end else if (k < 14 + DUMMY_CLKS) begin
                  if (mem_sd_oen_o != 4'h0) w.bad++;
               end else begin
                  if (mem_sd_oen_o != 4'h0) w.bad++;
                  j = k - 14 - DUMMY_CLKS;
                  b = dev_rd(w.ram, int'(w.addr) + j / 2);
                  mem_sd_i = (j % 2 == 0) ? b[7:4] : b[3:0];
                  w.nnib++;
               end
               k++;
            end
            if (in_win && !cs_low) begin
               in_win = 1'b0;
               if (w.ram && w.cmd == RAM_CMD_WR) begin
                  for (int i = 0; i < w.nnib / 2; i++)
                     dev_ram[int'(w.addr) + i] = w.wnib[8*(w.nnib/2 - 1 - i) +: 8];
               end
               obs_q.push_back(w);
            end
         end
         if (ack_o) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious_ack: ack_o=1 with no request pending, expected 0");
            end else begin
               e = exp_q.pop_front();
               check("ack_latency", 64'(cyc - e.accept), 64'(e.lat));
               check("rdata", 64'(rdata_o), 64'(e.rdata));
               if (e.bus) begin
                  if (obs_q.size() == 0) begin
                     tests++;
                     fails++;
                     $display("FAIL bus_txn: no chip-select window seen, expected one");
                  end else begin
                     o = obs_q.pop_front();
                     check("bus_cmd", 64'(o.cmd), 64'(e.cmd));
                     check("bus_addr", 64'(o.addr), 64'(e.addr));
                     check("bus_device", 64'(o.ram), 64'(e.ram));
                     check("bus_nibbles", 64'(o.nnib), 64'(e.nnib));
                     check("bus_line_ctrl", 64'(o.bad), 64'd0);
                     if (!e.rd) check("bus_wdata", o.wnib, e.wnib);
                  end
               end else begin
                  check("no_bus_activity", 64'(obs_q.size()), 64'd0);
               end
               $display("[TB] cycle %0d: ack rdata=%08h", cyc, rdata_o);
            end
         end
      end
   end

   initial begin
      int start;
      int r;
      logic [24:0] a;
      sel_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011,
                  4'b0110, 4'b1100, 4'b0111, 4'b1110, 4'b1111};

      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      check("rst_cs_rom", 64'(mem_cs_rom_on), 64'd1);
      check("rst_cs_ram", 64'(mem_cs_ram_on), 64'd1);
      check("rst_sck", 64'(mem_sck_o), 64'd0);
      check("rst_sd_o", 64'(mem_sd_o), 64'd0);
      check("rst_oen", 64'(mem_sd_oen_o), 64'd0);
      check("rst_ack", 64'(ack_o), 64'd0);
      check("rst_rdata", 64'(rdata_o), 64'd0);
      @(posedge clk);
      #1;

      // Directed cases
      issue(1'b0, 25'h0000100, 4'hF, 32'h0);
      wait_ack();
      stb_i = 1'b0;
      issue(1'b1, 25'h1000008, 4'hF, 32'hDEADBEEF);
      wait_ack();
      stb_i = 1'b0;
      issue(1'b1, 25'h1000010, 4'b0100, 32'h00AB0000);
      wait_ack();
      stb_i = 1'b0;
      issue(1'b1, 25'h0000040, 4'hF, 32'h12345678);
      wait_ack();
      stb_i = 1'b0;
      issue(1'b0, 25'h1000008, 4'h0, 32'h0);
      wait_ack();
      stb_i = 1'b0;
      issue(1'b0, 25'h1000010, 4'h0, 32'h0);
      wait_ack();
      stb_i = 1'b0;

      // Reset in the middle of a read
      issue(1'b0, 25'h0000100, 4'h0, 32'h0);
      start = cyc;
      repeat (20) @(posedge clk);
      #1;
      rst_i = 1'b1;
      stb_i = 1'b0;
      void'(exp_q.pop_back());
      last_rdata = '0;
      $display("[TB] cycle %0d: reset asserted %0d cycles into a read", cyc, cyc - start);
      @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      check("midrst_cs_rom", 64'(mem_cs_rom_on), 64'd1);
      check("midrst_cs_ram", 64'(mem_cs_ram_on), 64'd1);
      check("midrst_sck", 64'(mem_sck_o), 64'd0);
      check("midrst_oen", 64'(mem_sd_oen_o), 64'd0);
      check("midrst_ack", 64'(ack_o), 64'd0);
      check("midrst_rdata", 64'(rdata_o), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      issue(1'b0, 25'h0000100, 4'h0, 32'h0);
      wait_ack();
      stb_i = 1'b0;

      // Back-to-back reads with stb_i held
      @(posedge clk);
      #1;
      issue(1'b0, 25'h0000104, 4'h0, 32'h0);
      wait_ack();
      issue(1'b0, 25'h1000008, 4'h0, 32'h0);
      wait_ack();
      stb_i = 1'b0;

      // Randomised traffic
      for (int t = 0; t < 40; t++) begin
         r = int'($urandom_range(0, 9));
         if (r < 4) begin
            a = {1'b0, 24'($urandom_range(0, 255))};
            issue(1'b0, a, 4'h0, 32'h0);
         end else if (r < 6) begin
            a = {1'b1, 24'($urandom_range(0, 63))};
            issue(1'b0, a, 4'h0, 32'h0);
         end else if (r < 9) begin
            a = {1'b1, 24'($urandom_range(0, 63))};
            issue(1'b1, a, sel_tab[$urandom_range(0, 9)], $urandom);
         end else begin
            a = {1'b0, 24'($urandom_range(0, 255))};
            issue(1'b1, a, 4'hF, $urandom);
         end
         wait_ack();
         if ($urandom_range(0, 1) == 0) begin
            stb_i = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
      end
      stb_i = 1'b0;

      repeat (10) @(posedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      check("bus_log_drained", 64'(obs_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
